// File: rtl/gtp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : gtp_pkg
// Purpose  : Shared 8b/10b control characters and lane state encoding for
//            the transceiver link controller.
// Revision : 1.0
// ---------------------------------------------------------------------------
package gtp_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma character
  localparam logic [7:0] D16_2 = 8'h50;  // idle filler character

  typedef enum logic [1:0] {
    RESET     = 2'd0,
    WAIT_DONE = 2'd1,
    ALIGN     = 2'd2,
    LOCKED    = 2'd3
  } lane_state_t;

endpackage
`default_nettype wire

// File: rtl/gtp_lane_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : gtp_lane_ctrl
// Purpose  : One transceiver lane: reset sequencing, comma alignment, lock
//            tracking, retry counting and the registered tx idle/user mux.
// Revision : 1.0
// ---------------------------------------------------------------------------
module gtp_lane_ctrl
  import gtp_pkg::*;
#(
  parameter  int DATA_W      = 16,
  parameter  int LOCK_CNT    = 64,
  parameter  int LOSS_CNT    = 4,
  parameter  int TIMEOUT_CYC = 2**20,
  parameter  int RST_CYC     = 16,
  localparam int K_W         = DATA_W / 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              gt_reset_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [K_W-1:0]    rx_charisk,
  input  logic              rx_err,
  input  logic [DATA_W-1:0] tx_user_data,
  input  logic [K_W-1:0]    tx_user_charisk,
  output logic              soft_reset,
  output logic [DATA_W-1:0] tx_data,
  output logic [K_W-1:0]    tx_charisk,
  output logic              lane_locked,
  output logic [7:0]        retry_cnt
);

  localparam int RST_W  = $clog2(RST_CYC) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC) + 1;
  localparam int GOOD_W = $clog2(LOCK_CNT) + 1;
  localparam int BAD_W  = $clog2(LOSS_CNT) + 1;

  lane_state_t       state, state_nxt;
  logic [RST_W-1:0]  rst_cnt, rst_nxt;
  logic [TO_W-1:0]   to_cnt, to_nxt, to_inc;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [BAD_W-1:0]  bad_cnt, bad_nxt;
  logic [7:0]        retry_nxt;
  logic              good_word, bad_word;
  logic              lock_hit, loss_hit, to_hit;
  logic [DATA_W-1:0] idle_data;
  logic [K_W-1:0]    idle_k;

  // Classify the received word: good comma, bad (error or misplaced comma), or neutral.
  always_comb begin
    good_word = (rx_data[7:0] == K28_5) && rx_charisk[0] && !rx_err;
    bad_word  = rx_err;
    for (int b = 1; b < K_W; b++) begin
      if (rx_charisk[b]) good_word = 1'b0;
      if (rx_charisk[b] && (rx_data[8*b +: 8] == K28_5)) bad_word = 1'b1;
    end
  end

  // Idle word: comma in byte0, D16.2 filler in every other byte.
  always_comb begin
    for (int b = 0; b < K_W; b++) begin
      idle_data[8*b +: 8] = (b == 0) ? K28_5 : D16_2;
      idle_k[b]           = (b == 0);
    end
  end

  // Next-state and counter update; link-down beats lock/loss/timeout.
  always_comb begin
    state_nxt = state;
    rst_nxt   = '0;
    to_nxt    = to_cnt;
    good_nxt  = '0;
    bad_nxt   = '0;
    retry_nxt = retry_cnt;

    // Timeout counter saturates so a late done-drop cannot wrap it.
    to_inc   = (to_cnt == TO_W'(TIMEOUT_CYC)) ? to_cnt : to_cnt + 1'b1;
    to_hit   = (to_cnt >= TO_W'(TIMEOUT_CYC - 1));
    lock_hit = good_word && (good_cnt == GOOD_W'(LOCK_CNT - 1));
    loss_hit = bad_word && (bad_cnt == BAD_W'(LOSS_CNT - 1));

    case (state)
      RESET: begin
        to_nxt = '0;
        if (rst_cnt == RST_W'(RST_CYC - 1)) state_nxt = WAIT_DONE;
        else                                rst_nxt   = rst_cnt + 1'b1;
      end
      WAIT_DONE: begin
        if (to_hit) begin
          state_nxt = RESET;
          to_nxt    = '0;
          retry_nxt = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 1'b1;
        end else begin
          to_nxt = to_inc;
          if (gt_reset_done) state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        if (!gt_reset_done) begin
          state_nxt = WAIT_DONE;
          to_nxt    = to_inc;
        end else if (lock_hit) begin
          state_nxt = LOCKED;
          to_nxt    = '0;
        end else if (to_hit) begin
          state_nxt = RESET;
          to_nxt    = '0;
          retry_nxt = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 1'b1;
        end else begin
          to_nxt   = to_inc;
          good_nxt = good_word ? good_cnt + 1'b1 : '0;
        end
      end
      LOCKED: begin
        to_nxt = '0;
        if (!gt_reset_done)  state_nxt = WAIT_DONE;
        else if (loss_hit)   state_nxt = ALIGN;
        else                 bad_nxt   = bad_word ? bad_cnt + 1'b1 : '0;
      end
      default: state_nxt = RESET;
    endcase
  end

  // State register and counters.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= RESET;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rst_cnt   <= rst_nxt;
      to_cnt    <= to_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // Lock flag follows the state; tx switches to user data once the flag is up.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      lane_locked <= 1'b0;
      tx_data     <= idle_data;
      tx_charisk  <= idle_k;
    end else begin
      lane_locked <= (state == LOCKED);
      tx_data     <= lane_locked ? tx_user_data    : idle_data;
      tx_charisk  <= lane_locked ? tx_user_charisk : idle_k;
    end
  end

  assign soft_reset = (state == RESET);

endmodule
`default_nettype wire

// File: rtl/gtp_link_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : gtp_link_ctrl
// Purpose  : Multi-lane transceiver link controller: one gtp_lane_ctrl per
//            lane plus the registered all-lanes-locked flag.
// Revision : 1.0
// ---------------------------------------------------------------------------
module gtp_link_ctrl
  import gtp_pkg::*;
#(
  parameter  int LANES       = 1,
  parameter  int DATA_W      = 16,
  parameter  int LOCK_CNT    = 64,
  parameter  int LOSS_CNT    = 4,
  parameter  int TIMEOUT_CYC = 2**20,
  parameter  int RST_CYC     = 16,
  localparam int K_W         = DATA_W / 8
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic [LANES-1:0]        gt_reset_done,
  input  logic [LANES*DATA_W-1:0] rx_data,
  input  logic [LANES*K_W-1:0]    rx_charisk,
  input  logic [LANES-1:0]        rx_err,
  input  logic [LANES*DATA_W-1:0] tx_user_data,
  input  logic [LANES*K_W-1:0]    tx_user_charisk,
  output logic [LANES-1:0]        soft_reset,
  output logic [LANES*DATA_W-1:0] tx_data,
  output logic [LANES*K_W-1:0]    tx_charisk,
  output logic [LANES-1:0]        lane_locked,
  output logic                    all_locked,
  output logic [LANES*8-1:0]      retry_cnt
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gtp_lane_ctrl #(
      .DATA_W      (DATA_W),
      .LOCK_CNT    (LOCK_CNT),
      .LOSS_CNT    (LOSS_CNT),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .RST_CYC     (RST_CYC)
    ) u_lane (
      .sysclk          (sysclk),
      .reset           (reset),
      .gt_reset_done   (gt_reset_done[i]),
      .rx_data         (rx_data[i*DATA_W +: DATA_W]),
      .rx_charisk      (rx_charisk[i*K_W +: K_W]),
      .rx_err          (rx_err[i]),
      .tx_user_data    (tx_user_data[i*DATA_W +: DATA_W]),
      .tx_user_charisk (tx_user_charisk[i*K_W +: K_W]),
      .soft_reset      (soft_reset[i]),
      .tx_data         (tx_data[i*DATA_W +: DATA_W]),
      .tx_charisk      (tx_charisk[i*K_W +: K_W]),
      .lane_locked     (lane_locked[i]),
      .retry_cnt       (retry_cnt[i*8 +: 8])
    );
  end

  // Link is up only when every lane reports lock.
  always_ff @(posedge sysclk) begin
    if (reset) all_locked <= 1'b0;
    else       all_locked <= &lane_locked;
  end

endmodule
`default_nettype wire

// File: doc/gtp_link_ctrl.md
GTP_LINK_CTRL -- requirements
Module: gtp_link_ctrl

Interface
REQ-001 The block SHALL take parameter LANES, default 1, giving the number of transceiver lanes controlled.
REQ-002 The block SHALL take parameter DATA_W, default 16, giving the per-lane word width; it is a multiple of 8, and K_W = DATA_W/8.
REQ-003 The block SHALL take parameter LOCK_CNT, default 64, giving the number of consecutive good comma words needed to declare lock.
REQ-004 The block SHALL take parameter LOSS_CNT, default 4, giving the number of consecutive bad words needed to drop lock.
REQ-005 The block SHALL take parameter TIMEOUT_CYC, default 2**20, giving the cycles allowed in WAIT_DONE plus ALIGN before a retry.
REQ-006 The block SHALL take parameter RST_CYC, default 16, giving the width in cycles of the soft_reset pulse.
REQ-007 Clock sysclk: input, 1 bit. One clock for the whole block; all inputs are already synchronous to sysclk.
REQ-008 Reset reset: input, 1 bit. Synchronous, active-high.
REQ-009 Input gt_reset_done: LANES bits, per-lane transceiver FSM reset-done.
REQ-010 Input rx_data: LANES*DATA_W bits, received words.
REQ-011 Input rx_charisk: LANES*K_W bits, per-byte K flags.
REQ-012 Input rx_err: LANES bits, disparity error or not-in-table, ORed per lane.
REQ-013 Input tx_user_data: LANES*DATA_W bits, user transmit words.
REQ-014 Input tx_user_charisk: LANES*K_W bits, user per-byte K flags.
REQ-015 Output soft_reset: LANES bits, per-lane transceiver reset request.
REQ-016 Output tx_data: LANES*DATA_W bits, registered words to the transceiver.
REQ-017 Output tx_charisk: LANES*K_W bits, registered K flags to the transceiver.
REQ-018 Output lane_locked: LANES bits, per-lane lock status.
REQ-019 Output all_locked: 1 bit, AND of lane_locked, registered.
REQ-020 Output retry_cnt: LANES*8 bits, per-lane retry count, saturating.

Function
REQ-021 Each lane SHALL run an independent FSM with states RESET, WAIT_DONE, ALIGN and LOCKED.
REQ-022 A good word SHALL be defined as: byte0 = 0xBC with its K bit set, no other K bit set, and rx_err low.
REQ-023 A bad word SHALL be defined as: rx_err high, or 0xBC with its K bit set in any byte other than byte0.
REQ-024 RESET SHALL hold soft_reset high for exactly RST_CYC cycles and then go to WAIT_DONE.
REQ-025 WAIT_DONE SHALL go to ALIGN on the first cycle gt_reset_done is high.
REQ-026 ALIGN SHALL count consecutive good words; any non-good word clears the count; the count reaching LOCK_CNT moves the lane to LOCKED on the next cycle.
REQ-027 LOCKED SHALL count consecutive bad words; a good word or a neutral data word clears the count; the count reaching LOSS_CNT returns the lane to ALIGN with the counters cleared.
REQ-028 A timeout counter SHALL run in WAIT_DONE and ALIGN, clear on entry to LOCKED, and on reaching TIMEOUT_CYC move the lane to RESET and increment retry_cnt, saturating at 255.
REQ-029 gt_reset_done low in ALIGN or LOCKED SHALL move the lane to WAIT_DONE, taking priority over lock, loss and timeout in the same cycle; the timeout counter is not cleared.
REQ-030 lane_locked SHALL be high exactly while the FSM is in LOCKED, registered, with a 1-cycle delay from the state transition.
REQ-031 When a lane is not LOCKED, its tx SHALL send the idle word: byte0 = 0xBC with K set, all other bytes 0x50 with K clear.
REQ-032 When a lane is LOCKED, its tx SHALL pass the tx_user_* inputs; the latency from input to tx output is 1 cycle.
REQ-033 All counters SHALL be sized with $clog2 of their limit plus 1 and SHALL never wrap.

Reset
REQ-034 On reset, every lane SHALL enter RESET with all counters at 0, retry_cnt at 0, soft_reset high, lane_locked and all_locked at 0, and tx outputs at the idle word.
REQ-035 Reset asserted mid-operation SHALL override every other condition in the same cycle.

Structure
REQ-036 The constants K28_5 (0xBC) and D16_2 (0x50) and the lane state enum SHALL live in the shared package gtp_pkg.
REQ-037 The per-lane FSM, counters and tx mux SHALL be the sub-module gtp_lane_ctrl, instantiated LANES times by a generate loop; gtp_link_ctrl itself only adds all_locked.

Verification
REQ-038 Reset, then gt_reset_done=1 and 64 good words -> lane_locked rises 65 cycles after ALIGN entry, and tx switches to user data one cycle later.
REQ-039 63 good words, 1 rx_err, then 64 good words -> lock is taken only after the second run.
REQ-040 Locked lane, then 3 bad words, 1 data word, then 4 bad words -> lock is held through the 3 and lost after the 4th.
REQ-041 gt_reset_done held 0 for TIMEOUT_CYC=100 -> soft_reset high for 16 cycles and retry_cnt=1; after 300 such timeouts retry_cnt=255.
REQ-042 LANES=4 with lane 2 never aligning -> all_locked=0 and lanes 0, 1 and 3 locked; gt_reset_done drop coinciding with the LOCK_CNT-th good word -> WAIT_DONE, not LOCKED.
